// File: rtl/fir_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the fir_mac_seq tap engine.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int OUT_W  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    MAC   = ST_MAC,
    DRAIN = ST_DRAIN,
    OUT   = ST_OUT
  } state_e;

  // Widened copy of a product; callers size-cast it down to their accumulator width.
  function automatic logic signed [63:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return 64'(p);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [63:0] v);
    if (v > 64'sd32767)
      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < -64'sd32768)
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Unsigned 4x4 vedic (urdhva-tiryagbhyam) multiplier cell built from 2x2 partial products.
module vedic_4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [3:0] q_ll, q_lh, q_hl, q_hh;
  logic [4:0] mid;
  logic [5:0] upper;

  assign q_ll = {2'b00, a_i[1:0]} * {2'b00, b_i[1:0]};
  assign q_lh = {2'b00, a_i[1:0]} * {2'b00, b_i[3:2]};
  assign q_hl = {2'b00, a_i[3:2]} * {2'b00, b_i[1:0]};
  assign q_hh = {2'b00, a_i[3:2]} * {2'b00, b_i[3:2]};

  // Cross terms sit two bits up; the high-by-high term sits four bits up.
  assign mid   = {1'b0, q_lh} + {1'b0, q_hl};
  assign upper = {q_hh, 2'b00} + {1'b0, mid} + {4'b0000, q_ll[3:2]};
  assign p_o   = {upper, q_ll[1:0]};

endmodule

// File: rtl/vedic_signed_8x8.sv
// Signed 8x8 multiplier: sign-magnitude wrapper around four vedic_4x4 cells.
module vedic_signed_8x8
  import fir_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [PROD_W-1:0] p_o
);

  logic [DATA_W-1:0] mag_a, mag_b;
  logic [7:0]        pp_ll, pp_lh, pp_hl, pp_hh;
  logic [8:0]        mid;
  logic [11:0]       upper;
  logic [15:0]       mag_p;

  // -128 maps to magnitude 128, which still fits in 8 unsigned bits.
  assign mag_a = a_i[DATA_W-1] ? (~a_i + DATA_W'(1)) : a_i;
  assign mag_b = b_i[DATA_W-1] ? (~b_i + DATA_W'(1)) : b_i;

  vedic_4x4 u_ll (.a_i(mag_a[3:0]), .b_i(mag_b[3:0]), .p_o(pp_ll));
  vedic_4x4 u_lh (.a_i(mag_a[3:0]), .b_i(mag_b[7:4]), .p_o(pp_lh));
  vedic_4x4 u_hl (.a_i(mag_a[7:4]), .b_i(mag_b[3:0]), .p_o(pp_hl));
  vedic_4x4 u_hh (.a_i(mag_a[7:4]), .b_i(mag_b[7:4]), .p_o(pp_hh));

  assign mid   = {1'b0, pp_lh} + {1'b0, pp_hl};
  assign upper = {pp_hh, 4'b0000} + {3'b000, mid} + {8'h00, pp_ll[7:4]};
  assign mag_p = {upper, pp_ll[3:0]};

  assign p_o = (a_i[DATA_W-1] ^ b_i[DATA_W-1]) ? -mag_p : mag_p;

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR tap engine: one 8-bit sample in, TAPS serial MACs, one 16-bit result out.
// Define FIR_SAT_EN to clamp the output to int16; otherwise the output wraps.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int TAPS      = 8,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [DATA_W-1:0]   coef_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data
);

  localparam int AW = $clog2(TAPS);

  state_e                   state_q;
  logic [AW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_shift;
  logic signed [PROD_W-1:0] p_q, prod;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] h_q [TAPS];
  logic signed [OUT_W-1:0]  out_data_q, out_fmt;
  logic                     out_valid_q;
  logic                     accept, last_tap;

  vedic_signed_8x8 u_mul (
    .a_i (x_q[k_q]),
    .b_i (h_q[k_q]),
    .p_o (prod)
  );

  assign acc_d     = acc_q + ACC_W'(sext_prod(p_q));
  assign acc_shift = acc_d >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
  assign out_fmt = sat_out(64'(acc_shift));
`else
  assign out_fmt = OUT_W'(acc_shift);
`endif

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_tap  = (k_q == AW'(TAPS - 1));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // NOTE: every register here is updated with <=, so the delay-line shift and the
  // acc/p_q pipeline all read pre-edge values; blocking assignments would collapse them.
  // NOTE: the delay line and coefficients are plain flops, so reset clears them in place
  // rather than through a sequenced clear as a RAM would need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_we && (32'(coef_addr) < TAPS))
            h_q[coef_addr] <= coef_data;
          if (accept) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++)
              x_q[i] <= x_q[i-1];
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          p_q <= prod;
          // p_q still holds a stale product during the first tap cycle.
          if (k_q != '0)
            acc_q <= acc_d;
          k_q <= k_q + AW'(1);
          if (last_tap)
            state_q <= DRAIN;
        end
        DRAIN: begin
          out_data_q  <= out_fmt;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
